// File: rtl/note_draw_scheduler_pkg.sv
// Shared definitions for the note-display draw scheduler: FSM states, note codes,
// screen geometry and the packed draw-request record.
package note_draw_scheduler_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_LOAD = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] NOTE_BLANK = 4'd0;
  localparam logic [3:0] NOTE_A     = 4'd1;
  localparam logic [3:0] NOTE_AS    = 4'd2;
  localparam logic [3:0] NOTE_B     = 4'd3;
  localparam logic [3:0] NOTE_C     = 4'd4;
  localparam logic [3:0] NOTE_CS    = 4'd5;
  localparam logic [3:0] NOTE_D     = 4'd6;
  localparam logic [3:0] NOTE_DS    = 4'd7;
  localparam logic [3:0] NOTE_E     = 4'd8;
  localparam logic [3:0] NOTE_F     = 4'd9;
  localparam logic [3:0] NOTE_FS    = 4'd10;
  localparam logic [3:0] NOTE_G     = 4'd11;
  localparam logic [3:0] NOTE_GS    = 4'd12;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int GLYPH    = 12;

  localparam int DEF_DRAW_CYCLES = 900;
  localparam int DEF_INIT_CYCLES = 19300;

  typedef struct packed {
    logic [3:0] note;
    logic [1:0] octave;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } req_t;

  // Codes above the last semitone have no glyph; draw them as a blank.
  function automatic logic [3:0] sanitize_note(input logic [3:0] n);
    return (n > NOTE_GS) ? NOTE_BLANK : n;
  endfunction

endpackage

// File: rtl/note_draw_scheduler_req_fifo.sv
// Synchronous request FIFO (DEPTH x 24-bit draw records) with asynchronous active-low reset.
module req_fifo
  import note_draw_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  req_t                     din,
  output req_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  req_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/note_draw_scheduler.sv
// Queues note-glyph draw requests and feeds them one at a time to the draw engine,
// holding each request stable for the engine's full clear+draw pass.
module note_draw_scheduler
  import note_draw_scheduler_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int LD_CYCLES   = 2,
  parameter int DRAW_CYCLES = DEF_DRAW_CYCLES,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int CNT_W       = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_note,
  input  logic [1:0] req_octave,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  output logic [3:0] note,
  output logic [1:0] octave,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour_in,
  output logic       ld_note,
  output logic       busy
);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LAST   = CNT_W'(LD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAW_LAST = CNT_W'(DRAW_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   ld_nxt;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  req_t                   push_req;
  req_t                   head;

  assign push_req = '{note:   sanitize_note(req_note),
                      octave: req_octave,
                      x:      req_x,
                      y:      req_y,
                      colour: req_colour};

  req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .pop   (pop),
    .din   (push_req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign req_ready = !fifo_full;
  assign busy      = !((state == S_IDLE) && (fifo_count == '0));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_nxt    = ld_note;
    pop       = 1'b0;
    case (state)
      S_INIT: begin
        if (cnt == INIT_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          ld_nxt    = 1'b1;
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (cnt == LD_LAST) begin
          ld_nxt    = 1'b0;
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // The count starts on the first cycle ld_note is low.
        if (cnt == DRAW_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_INIT;
        cnt_nxt   = '0;
        ld_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_INIT;
      cnt       <= '0;
      ld_note   <= 1'b0;
      note      <= '0;
      octave    <= '0;
      x         <= '0;
      y         <= '0;
      colour_in <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ld_note <= ld_nxt;
      // Engine inputs move only when a new request is popped.
      if (pop) begin
        note      <= head.note;
        octave    <= head.octave;
        x         <= head.x;
        y         <= head.y;
        colour_in <= head.colour;
      end
    end
  end

endmodule
